// File: rtl/srk_pkg.sv
// Shared SRM opcode constants, sequencer state codes and the width-to-secondary-opcode helper.
package srk_pkg;

   localparam logic [1:0] PRI_SECOND  = 2'b00;
   localparam logic [1:0] PRI_EXTZ_MR = 2'b01;
   localparam logic [1:0] PRI_EXTZ_MM = 2'b10;

   // Literal ops sit above the 0..32 width range so they never alias a width code.
   localparam logic [5:0] SEC_LITZERO = 6'b110000;
   localparam logic [5:0] SEC_LITONE  = 6'b110001;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LATCH = 3'd1;
   localparam logic [2:0] ST_P1    = 3'd2;
   localparam logic [2:0] ST_P2    = 3'd3;
   localparam logic [2:0] ST_SEXT  = 3'd4;
   localparam logic [2:0] ST_HOLD  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   function automatic logic [5:0] srk_width_to_sec(input logic [5:0] width);
      return ~width;
   endfunction

endpackage

// File: rtl/srm_pass_plan.sv
// Combinational pass planner: decides how a field splits across the longword boundary.
module srm_pass_plan (
   input  logic [4:0] pos,
   input  logic [5:0] size,
   input  logic       sext,
   output logic       need_p2,
   output logic [5:0] w1,
   output logic [5:0] w2,
   output logic       need_sext
);

   logic [6:0] fend;
   logic [5:0] room;

   assign fend      = {2'b00, pos} + {1'b0, size};
   assign room      = 6'd32 - {1'b0, pos};
   assign need_p2   = (fend > 7'd32);
   assign w1        = (size < room) ? size : room;
   assign w2        = need_p2 ? 6'(fend - 7'd32) : 6'd0;
   // A 32-bit field already fills the longword, so there is nothing to sign-fill.
   assign need_sext = sext && (size != 6'd0) && (size < 6'd32);

endmodule

// File: rtl/srm_field_seq.sv
// SRM field-extract microsequencer: turns one extract request into the per-cycle SRM control stream.
import srk_pkg::*;

module srm_field_seq #(
   parameter int MAX_SIZE = 32,
   parameter int LAT_HOLD = 1
) (
   input  logic       clk_h,
   input  logic       reset_h,
   input  logic       req_h,
   input  logic [4:0] pos_h,
   input  logic [5:0] size_h,
   input  logic       sext_h,
   input  logic       abort_h,
   output logic       busy_h,
   output logic       done_h,
   output logic       err_h,
   output logic       phase_h,
   output logic [1:0] pri_l,
   output logic [5:0] sec_l,
   output logic [2:0] shf_l,
   output logic [2:0] litrl_h,
   output logic [1:0] pass_h
);

   localparam logic [6:0] MAX_SIZE_W = 7'(MAX_SIZE);
   localparam logic [1:0] HOLD_INIT  = (LAT_HOLD > 0) ? 2'(LAT_HOLD - 1) : 2'd0;
   localparam logic [2:0] ST_AFTER   = (LAT_HOLD == 0) ? ST_DONE : ST_HOLD;

   logic [2:0] state_q, state_d;
   logic [4:0] pos_q, pos_d;
   logic [5:0] size_q, size_d;
   logic       sext_q, sext_d;
   logic [1:0] hold_q, hold_d;
   logic       phase_q, phase_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [1:0] pri_q, pri_d;
   logic [5:0] sec_q, sec_d;
   logic [2:0] shf_q, shf_d;
   logic [2:0] lit_q, lit_d;
   logic [1:0] pass_q, pass_d;

   logic       need_p2, need_sext;
   logic [5:0] w1, w2;

   srm_pass_plan u_plan (
      .pos       (pos_q),
      .size      (size_q),
      .sext      (sext_q),
      .need_p2   (need_p2),
      .w1        (w1),
      .w2        (w2),
      .need_sext (need_sext)
   );

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      size_d  = size_q;
      sext_d  = sext_q;
      hold_d  = hold_q;
      phase_d = phase_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      pri_d   = pri_q;
      sec_d   = sec_q;
      shf_d   = shf_q;
      lit_d   = lit_q;
      pass_d  = pass_q;

      case (state_q)
         ST_IDLE: begin
            if (req_h) begin
               if ({1'b0, size_h} > MAX_SIZE_W) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_LATCH;
                  pos_d   = pos_h;
                  size_d  = size_h;
                  sext_d  = sext_h;
               end
            end
         end
         ST_LATCH: state_d = ST_P1;
         ST_P1: begin
            if (size_q == 6'd0) state_d = ST_AFTER;
            else if (need_p2)   state_d = ST_P2;
            else if (need_sext) state_d = ST_SEXT;
            else                state_d = ST_AFTER;
         end
         ST_P2:   state_d = need_sext ? ST_SEXT : ST_AFTER;
         ST_SEXT: state_d = ST_AFTER;
         ST_HOLD: begin
            if (hold_q == 2'd0) state_d = ST_DONE;
            else                hold_d  = hold_q - 2'd1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if ((state_q != ST_IDLE) && abort_h) state_d = ST_IDLE;
      if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) hold_d = HOLD_INIT;

      // Outputs are registered alongside the state, so they are decoded from the next state.
      case (state_d)
         ST_IDLE, ST_LATCH: begin
            phase_d = (state_d == ST_IDLE);
            busy_d  = (state_d == ST_LATCH);
            pri_d   = ~PRI_SECOND;
            sec_d   = ~SEC_LITZERO;
            shf_d   = 3'b111;
            lit_d   = 3'd0;
            pass_d  = 2'd0;
         end
         ST_P1: begin
            phase_d = 1'b1;
            busy_d  = 1'b1;
            lit_d   = 3'd0;
            pass_d  = 2'd0;
            if (size_q == 6'd0) begin
               pri_d = ~PRI_SECOND;
               sec_d = ~SEC_LITZERO;
               shf_d = 3'b111;
            end else begin
               pri_d = ~PRI_EXTZ_MR;
               sec_d = srk_width_to_sec(w1);
               shf_d = ~pos_q[4:2];
            end
         end
         ST_P2: begin
            phase_d = 1'b1;
            busy_d  = 1'b1;
            pri_d   = ~PRI_EXTZ_MM;
            sec_d   = srk_width_to_sec(w2);
            shf_d   = 3'b111;
            lit_d   = 3'd0;
            pass_d  = 2'd1;
         end
         ST_SEXT: begin
            phase_d = 1'b1;
            busy_d  = 1'b1;
            pri_d   = ~PRI_SECOND;
            sec_d   = ~SEC_LITONE;
            shf_d   = 3'b111;
            lit_d   = 3'b111;
            pass_d  = 2'd2;
         end
         ST_HOLD: begin
            phase_d = 1'b1;
            busy_d  = 1'b1;
         end
         ST_DONE: begin
            phase_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b1;
         end
         default: begin
            phase_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_h or posedge reset_h) begin
      if (reset_h) begin
         state_q <= ST_IDLE;
         pos_q   <= 5'd0;
         size_q  <= 6'd0;
         sext_q  <= 1'b0;
         hold_q  <= 2'd0;
         phase_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         pri_q   <= ~PRI_SECOND;
         sec_q   <= ~SEC_LITZERO;
         shf_q   <= 3'b111;
         lit_q   <= 3'd0;
         pass_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         hold_q  <= hold_d;
         phase_q <= phase_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         pri_q   <= pri_d;
         sec_q   <= sec_d;
         shf_q   <= shf_d;
         lit_q   <= lit_d;
         pass_q  <= pass_d;
      end
   end

   assign busy_h  = busy_q;
   assign done_h  = done_q;
   assign err_h   = err_q;
   assign phase_h = phase_q;
   assign pri_l   = pri_q;
   assign sec_l   = sec_q;
   assign shf_l   = shf_q;
   assign litrl_h = lit_q;
   assign pass_h  = pass_q;

endmodule

// File: tb/tb_srm_field_seq.sv
// Scoreboard bench for srm_field_seq: expected per-cycle control words are queued at request time.
import srk_pkg::*;

module tb_srm_field_seq;

   typedef struct packed {
      logic       phase;
      logic       busy;
      logic       done;
      logic       err;
      logic [1:0] pri;
      logic [5:0] sec;
      logic [2:0] shf;
      logic [2:0] lit;
      logic [1:0] pass;
   } ctl_t;

   logic       clk_h = 1'b0;
   logic       reset_h = 1'b1;
   logic       req_h = 1'b0;
   logic [4:0] pos_h = 5'd0;
   logic [5:0] size_h = 6'd0;
   logic       sext_h = 1'b0;
   logic       abort_h = 1'b0;

   logic       busy_h, done_h, err_h, phase_h;
   logic [1:0] pri_l, pass_h;
   logic [5:0] sec_l;
   logic [2:0] shf_l, litrl_h;

   logic       busy2, done2, err2, phase2;
   logic [1:0] pri2, pass2;
   logic [5:0] sec2;
   logic [2:0] shf2, lit2;

   int   total = 0;
   int   bad = 0;
   ctl_t exp_q[$];

   always #5 clk_h = ~clk_h;

   srm_field_seq #(.MAX_SIZE(32), .LAT_HOLD(0)) dut (
      .clk_h(clk_h), .reset_h(reset_h), .req_h(req_h), .pos_h(pos_h), .size_h(size_h),
      .sext_h(sext_h), .abort_h(abort_h), .busy_h(busy_h), .done_h(done_h), .err_h(err_h),
      .phase_h(phase_h), .pri_l(pri_l), .sec_l(sec_l), .shf_l(shf_l), .litrl_h(litrl_h),
      .pass_h(pass_h)
   );

   srm_field_seq #(.MAX_SIZE(32), .LAT_HOLD(2)) dut2 (
      .clk_h(clk_h), .reset_h(reset_h), .req_h(req_h), .pos_h(pos_h), .size_h(size_h),
      .sext_h(sext_h), .abort_h(abort_h), .busy_h(busy2), .done_h(done2), .err_h(err2),
      .phase_h(phase2), .pri_l(pri2), .sec_l(sec2), .shf_l(shf2), .litrl_h(lit2),
      .pass_h(pass2)
   );

   function automatic ctl_t obs1();
      return ctl_t'({phase_h, busy_h, done_h, err_h, pri_l, sec_l, shf_l, litrl_h, pass_h});
   endfunction

   function automatic ctl_t obs2();
      return ctl_t'({phase2, busy2, done2, err2, pri2, sec2, shf2, lit2, pass2});
   endfunction

   function automatic ctl_t idle_word();
      ctl_t c;
      c.phase = 1'b1; c.busy = 1'b0; c.done = 1'b0; c.err = 1'b0;
      c.pri = ~PRI_SECOND; c.sec = ~SEC_LITZERO; c.shf = 3'b111; c.lit = 3'd0; c.pass = 2'd0;
      return c;
   endfunction

   // Reference model of the cycle-by-cycle stream following the accepting edge.
   task automatic push_model(input logic [4:0] p, input logic [5:0] s, input logic x, input int lh);
      ctl_t c;
      int   pi, si, fend, w1;
      pi = int'(p);
      si = int'(s);
      fend = pi + si;
      w1 = (si < 32 - pi) ? si : 32 - pi;
      c = idle_word();
      c.phase = 1'b0; c.busy = 1'b1;
      exp_q.push_back(c);
      c.phase = 1'b1;
      if (si != 0) begin
         c.pri = ~PRI_EXTZ_MR; c.shf = ~p[4:2]; c.sec = ~6'(w1);
      end
      exp_q.push_back(c);
      if (si != 0 && fend > 32) begin
         c.pri = ~PRI_EXTZ_MM; c.shf = 3'b111; c.sec = ~6'(fend - 32); c.pass = 2'd1;
         exp_q.push_back(c);
      end
      if (x && si != 0 && si < 32) begin
         c.pri = ~PRI_SECOND; c.sec = ~SEC_LITONE; c.shf = 3'b111; c.lit = 3'b111; c.pass = 2'd2;
         exp_q.push_back(c);
      end
      for (int i = 0; i < lh; i++) exp_q.push_back(c);
      c.done = 1'b1;
      exp_q.push_back(c);
      exp_q.push_back(idle_word());
   endtask

   task automatic run_op(input string name, input logic [4:0] p, input logic [5:0] s,
                         input logic x, input int extra_req, input logic abort_first);
      ctl_t got, want;
      int   n;
      push_model(p, s, x, 0);
      n = exp_q.size();
      req_h = 1'b1; pos_h = p; size_h = s; sext_h = x; abort_h = abort_first;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk_h); #1;
         want = exp_q.pop_front();
         got = obs1();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, k, got, want);
         end
         abort_h = 1'b0;
         if (k <= extra_req) begin
            req_h = 1'b1; pos_h = ~p; size_h = 6'd3; sext_h = ~x;
         end else begin
            req_h = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset_h = 1'b1;
      repeat (2) @(posedge clk_h);
      #1;
      total++;
      if (obs1() !== idle_word()) begin
         bad++; $display("FAIL reset_held got=%h want=%h", obs1(), idle_word());
      end
      total++;
      if (obs2() !== idle_word()) begin
         bad++; $display("FAIL reset_held2 got=%h want=%h", obs2(), idle_word());
      end
      reset_h = 1'b0;
      @(posedge clk_h); #1;
      total++;
      if (obs1() !== idle_word()) begin
         bad++; $display("FAIL reset_release got=%h want=%h", obs1(), idle_word());
      end
   endtask

   task automatic test_hold();
      ctl_t got, want;
      int   n;
      push_model(5'd4, 6'd8, 1'b0, 2);
      n = exp_q.size();
      req_h = 1'b1; pos_h = 5'd4; size_h = 6'd8; sext_h = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk_h); #1;
         req_h = 1'b0;
         want = exp_q.pop_front();
         got = obs2();
         total++;
         if (got !== want) begin
            bad++; $display("FAIL hold2 cycle=%0d got=%h want=%h", k, got, want);
         end
      end
   endtask

   task automatic test_err();
      logic [5:0] sizes [2];
      ctl_t       want;
      sizes[0] = 6'd40;
      sizes[1] = 6'd33;
      for (int i = 0; i < 2; i++) begin
         req_h = 1'b1; pos_h = 5'd3; size_h = sizes[i]; sext_h = 1'b1;
         @(posedge clk_h); #1;
         req_h = 1'b0;
         want = idle_word();
         want.err = 1'b1;
         total++;
         if (obs1() !== want) begin
            bad++; $display("FAIL err_pulse size=%0d got=%h want=%h", sizes[i], obs1(), want);
         end
         @(posedge clk_h); #1;
         total++;
         if (obs1() !== idle_word()) begin
            bad++; $display("FAIL err_clear size=%0d got=%h want=%h", sizes[i], obs1(), idle_word());
         end
      end
   endtask

   task automatic test_abort();
      ctl_t got, want;
      push_model(5'd28, 6'd8, 1'b0, 0);
      req_h = 1'b1; pos_h = 5'd28; size_h = 6'd8; sext_h = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk_h); #1;
         req_h = 1'b0;
         want = exp_q.pop_front();
         got = obs1();
         total++;
         if (got !== want) begin
            bad++; $display("FAIL abort_pre cycle=%0d got=%h want=%h", k, got, want);
         end
      end
      exp_q.delete();
      abort_h = 1'b1;
      @(posedge clk_h); #1;
      abort_h = 1'b0;
      total++;
      if (obs1() !== idle_word()) begin
         bad++; $display("FAIL abort_idle got=%h want=%h", obs1(), idle_word());
      end
      run_op("after_abort", 5'd4, 6'd8, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      ctl_t got, want;
      push_model(5'd28, 6'd8, 1'b1, 0);
      req_h = 1'b1; pos_h = 5'd28; size_h = 6'd8; sext_h = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         @(posedge clk_h); #1;
         req_h = 1'b0;
         want = exp_q.pop_front();
         got = obs1();
         total++;
         if (got !== want) begin
            bad++; $display("FAIL rstmid_pre cycle=%0d got=%h want=%h", k, got, want);
         end
      end
      exp_q.delete();
      #2 reset_h = 1'b1;
      #1;
      total++;
      if (obs1() !== idle_word()) begin
         bad++; $display("FAIL rstmid_async got=%h want=%h", obs1(), idle_word());
      end
      reset_h = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk_h); #1;
         total++;
         if (obs1() !== idle_word()) begin
            bad++; $display("FAIL rstmid_after cycle=%0d got=%h want=%h", k, obs1(), idle_word());
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_hold();
      run_op("single_4_8", 5'd4, 6'd8, 1'b0, 0, 1'b0);
      run_op("cross_28_8_sext", 5'd28, 6'd8, 1'b1, 0, 1'b0);
      run_op("size0_pos17", 5'd17, 6'd0, 1'b1, 0, 1'b0);
      run_op("full_0_32", 5'd0, 6'd32, 1'b1, 0, 1'b0);
      test_err();
      test_abort();
      run_op("abort_with_req_idle", 5'd9, 6'd5, 1'b1, 0, 1'b1);
      run_op("req_while_busy", 5'd4, 6'd8, 1'b0, 2, 1'b0);
      run_op("b2b_a_31_2", 5'd31, 6'd2, 1'b1, 0, 1'b0);
      run_op("b2b_b_8_24", 5'd8, 6'd24, 1'b1, 0, 1'b0);
      run_op("b2b_c_12_20", 5'd12, 6'd20, 1'b0, 0, 1'b0);
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
